// File: rtl/sd_sector_verifier_if.sv
// AXI-Lite read channel bundle (AR + R) between the sector verifier and the card reader.
// Latency: none; wires only.
// Backpressure: arready/rready follow standard AXI valid-ready semantics.
interface sd_sector_verifier_if;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sd_sector_verifier.sv
// Reads back NUM_SECTORS sectors word by word and checks each word against PATTERN_BASE + word index.
// Latency: arvalid rises the cycle after start; each read costs AR handshake + R handshake, no bubble between reads.
// Backpressure: one outstanding read; arvalid/araddr held until arready, rready held until rvalid; a stalled slave stalls the pass.
module sd_sector_verifier #(
    parameter logic [31:0] BASE_ADDR        = 32'h0,
    parameter int          NUM_SECTORS      = 4,
    parameter int          WORDS_PER_SECTOR = 128,
    parameter logic [31:0] PATTERN_BASE     = 32'h34120000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [31:0]          first_err_addr,
    output logic [7:0]           led,
    sd_sector_verifier_if.master m_axil
);

    localparam int SW = (NUM_SECTORS > 1) ? $clog2(NUM_SECTORS) : 1;
    localparam int WW = (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1;
    localparam logic [SW-1:0] LAST_SECTOR = SW'(NUM_SECTORS - 1);
    localparam logic [WW-1:0] LAST_WORD   = WW'(WORDS_PER_SECTOR - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   araddr_q, araddr_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [15:0]   err_q, err_d;
    logic [31:0]   first_q, first_d;
    logic [SW-1:0] sector_q, sector_d;
    logic [WW-1:0] word_q, word_d;

    // Sector stride is fixed at 512 bytes regardless of words per sector; sum wraps mod 2^32.
    function automatic logic [31:0] calc_addr(input logic [SW-1:0] s, input logic [WW-1:0] w);
        return BASE_ADDR + (32'(s) << 9) + (32'(w) << 2);
    endfunction

    // State and all datapath registers; reset mid-pass abandons the pass outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            araddr_q  <= 32'h0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 16'h0;
            first_q   <= 32'hFFFF_FFFF;
            sector_q  <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            first_q   <= first_d;
            sector_q  <= sector_d;
            word_q    <= word_d;
        end
    end

    logic          err_hit;
    logic          last_word;
    logic          last_sector;
    logic [SW-1:0] sector_inc;
    logic [WW-1:0] word_inc;

    // Next-state, read sequencing and error accounting.
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        first_d   = first_q;
        sector_d  = sector_q;
        word_d    = word_q;

        // A bad response and bad data on the same beat count as a single error.
        err_hit     = (m_axil.rresp != 2'b00) || (m_axil.rdata != (PATTERN_BASE + 32'(word_q)));
        last_word   = (word_q == LAST_WORD);
        last_sector = (sector_q == LAST_SECTOR);
        sector_inc  = sector_q + SW'(1);
        word_inc    = word_q + WW'(1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d     = 16'h0;
                    first_d   = 32'hFFFF_FFFF;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    sector_d  = '0;
                    word_d    = '0;
                    araddr_d  = calc_addr('0, '0);
                    arvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axil.rvalid) begin
                    rready_d = 1'b0;
                    if (err_hit) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'h1;
                        end
                        // Counter only saturates upward, so zero means no error seen yet this pass.
                        if (err_q == 16'h0) begin
                            first_d = araddr_q;
                        end
                    end
                    if (!last_word) begin
                        word_d = word_inc;
                    end else begin
                        word_d   = '0;
                        sector_d = sector_inc;
                    end
                    if (last_word && last_sector) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 16'h0);
                        state_d = S_DONE;
                    end else begin
                        araddr_d  = last_word ? calc_addr(sector_inc, '0) : calc_addr(sector_q, word_inc);
                        arvalid_d = 1'b1;
                        state_d   = S_ADDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status LEDs decode the current phase; a failing pass shows the low error count bits.
    always_comb begin
        led = 8'h01;
        case (state_q)
            S_IDLE: led = 8'h01;
            S_ADDR: led = 8'h02;
            S_DATA: led = 8'h04;
            S_DONE: led = pass_q ? 8'h08 : {1'b1, err_q[6:0]};
            default: led = 8'h01;
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

    assign m_axil.araddr  = araddr_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_sd_sector_verifier.sv
// Directed bench: a negedge-driven AXI-Lite read slave model plus a linear sequence of passes.
// Latency: checks are sampled 1-2 time units after the active edge.
// Backpressure: slave model inserts optional random 0-7 cycle arready/rvalid delays.
module tb_sd_sector_verifier;

    localparam logic [31:0] PAT = 32'h34120000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic [7:0]  led;

    sd_sector_verifier_if axil ();

    sd_sector_verifier #(
        .BASE_ADDR        (32'h0),
        .NUM_SECTORS      (4),
        .WORDS_PER_SECTOR (128),
        .PATTERN_BASE     (PAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .led            (led),
        .m_axil         (axil.master)
    );

    always #10 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Slave model state and configuration.
    int          reads       = 0;
    int          addr_err    = 0;
    int          stable_viol = 0;
    logic [31:0] exp_addr    = 32'h0;
    logic        delay_en    = 1'b0;
    logic        bad_data_en = 1'b0;
    logic [31:0] bad_data_addr = 32'h0;
    logic        bad_resp_en = 1'b0;
    logic [31:0] bad_resp_addr = 32'h0;
    int          s_phase     = 0;
    int          s_cnt       = -1;
    logic [31:0] s_addr      = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dly();
        return delay_en ? int'($urandom_range(0, 7)) : 0;
    endfunction

    // Read slave: acts on negedges so everything it drives is settled before the next posedge.
    initial begin
        axil.arready = 1'b0;
        axil.rvalid  = 1'b0;
        axil.rdata   = 32'h0;
        axil.rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                axil.arready = 1'b0;
                axil.rvalid  = 1'b0;
                s_phase      = 0;
                s_cnt        = -1;
            end else begin
                if (s_phase == 1 && axil.rvalid) begin
                    axil.rvalid = 1'b0;
                    s_phase     = 0;
                    s_cnt       = -1;
                end
                if (s_phase == 0) begin
                    if (axil.arready) begin
                        axil.arready = 1'b0;
                        s_phase      = 1;
                        reads++;
                        if (s_addr != exp_addr) addr_err++;
                        exp_addr = exp_addr + 32'd4;
                        s_cnt    = dly();
                    end else if (axil.arvalid) begin
                        if (s_cnt < 0) begin
                            s_cnt  = dly();
                            s_addr = axil.araddr;
                        end else if (axil.araddr != s_addr) begin
                            stable_viol++;
                        end
                        if (s_cnt == 0) axil.arready = 1'b1;
                        else s_cnt--;
                    end else if (s_cnt >= 0) begin
                        stable_viol++;
                    end
                end
                if (s_phase == 1 && !axil.rvalid) begin
                    if (s_cnt == 0) begin
                        axil.rvalid = 1'b1;
                        axil.rdata  = (PAT + {25'h0, s_addr[8:2]}) ^
                                      ((bad_data_en && s_addr == bad_data_addr) ? 32'h1 : 32'h0);
                        axil.rresp  = (bad_resp_en && s_addr == bad_resp_addr) ? 2'b10 : 2'b00;
                    end else begin
                        s_cnt--;
                    end
                end
            end
        end
    end

    task automatic reset_model();
        reads       = 0;
        exp_addr    = 32'h0;
        addr_err    = 0;
        stable_viol = 0;
        delay_en    = 1'b0;
        bad_data_en = 1'b0;
        bad_resp_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, {31'h0, done}, 32'h1);
    endtask

    task automatic wait_reads(input string tag, input int n, input int budget);
        int k = 0;
        while (reads < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, {31'h0, (reads >= n)}, 32'h1);
    endtask

    task automatic check_end(input string tag, input logic exp_pass, input logic [15:0] exp_err,
                             input logic [31:0] exp_first, input logic [7:0] exp_led);
        chk({tag, "_busy"},  {31'h0, busy}, 32'h0);
        chk({tag, "_pass"},  {31'h0, pass}, {31'h0, exp_pass});
        chk({tag, "_err"},   {16'h0, err_count}, {16'h0, exp_err});
        chk({tag, "_first"}, first_err_addr, exp_first);
        chk({tag, "_led"},   {24'h0, led}, {24'h0, exp_led});
        chk({tag, "_reads"}, reads, 512);
        chk({tag, "_addr"},  addr_err, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    {31'h0, busy}, 32'h0);
        chk("rst_done",    {31'h0, done}, 32'h0);
        chk("rst_pass",    {31'h0, pass}, 32'h0);
        chk("rst_err",     {16'h0, err_count}, 32'h0);
        chk("rst_first",   first_err_addr, 32'hFFFF_FFFF);
        chk("rst_led",     {24'h0, led}, 32'h1);
        chk("rst_arvalid", {31'h0, axil.arvalid}, 32'h0);
        chk("rst_rready",  {31'h0, axil.rready}, 32'h0);
        chk("rst_araddr",  axil.araddr, 32'h0);
        chk("rst_arprot",  {29'h0, axil.arprot}, 32'h0);
        #1 rst = 1'b0;

        // Clean pass with zero-delay slave.
        reset_model();
        pulse_start();
        chk("start_arvalid", {31'h0, axil.arvalid}, 32'h1);
        chk("start_araddr",  axil.araddr, 32'h0);
        chk("start_busy",    {31'h0, busy}, 32'h1);
        chk("start_led",     {24'h0, led}, 32'h2);
        @(posedge clk);
        #1;
        chk("data_rready",  {31'h0, axil.rready}, 32'h1);
        chk("data_arvalid", {31'h0, axil.arvalid}, 32'h0);
        chk("data_led",     {24'h0, led}, 32'h4);
        wait_done("clean_done", 20000);
        check_end("clean", 1'b1, 16'd0, 32'hFFFF_FFFF, 8'h08);
        chk("clean_last_addr", axil.araddr, 32'h7FC);

        // Single corrupted word at sector 2 word 5.
        reset_model();
        bad_data_en   = 1'b1;
        bad_data_addr = 32'h414;
        pulse_start();
        wait_done("corrupt_done", 20000);
        check_end("corrupt", 1'b0, 16'd1, 32'h414, 8'h81);

        // Error response with good data at 0x000 plus bad data at 0x600.
        reset_model();
        bad_resp_en   = 1'b1;
        bad_resp_addr = 32'h0;
        bad_data_en   = 1'b1;
        bad_data_addr = 32'h600;
        pulse_start();
        wait_done("resp_done", 20000);
        check_end("resp", 1'b0, 16'd2, 32'h0, 8'h82);

        // Re-run after a failed pass with a clean slave: all error state cleared.
        reset_model();
        pulse_start();
        chk("rerun_done_clr", {31'h0, done}, 32'h0);
        chk("rerun_err_clr",  {16'h0, err_count}, 32'h0);
        wait_done("rerun_done", 20000);
        check_end("rerun", 1'b1, 16'd0, 32'hFFFF_FFFF, 8'h08);

        // Random slave stalls on both channels.
        reset_model();
        delay_en = 1'b1;
        pulse_start();
        wait_done("rand_done", 40000);
        check_end("rand", 1'b1, 16'd0, 32'hFFFF_FFFF, 8'h08);
        chk("rand_stable", stable_viol, 0);

        // Start while busy is ignored; reset mid-pass aborts.
        reset_model();
        pulse_start();
        wait_reads("mid_r50", 50, 5000);
        pulse_start();
        chk("mid_busy", {31'h0, busy}, 32'h1);
        wait_reads("mid_r100", 100, 5000);
        chk("mid_addr", addr_err, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy",    {31'h0, busy}, 32'h0);
        chk("abort_done",    {31'h0, done}, 32'h0);
        chk("abort_pass",    {31'h0, pass}, 32'h0);
        chk("abort_err",     {16'h0, err_count}, 32'h0);
        chk("abort_first",   first_err_addr, 32'hFFFF_FFFF);
        chk("abort_led",     {24'h0, led}, 32'h1);
        chk("abort_arvalid", {31'h0, axil.arvalid}, 32'h0);
        chk("abort_rready",  {31'h0, axil.rready}, 32'h0);
        chk("abort_araddr",  axil.araddr, 32'h0);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_idle_busy", {31'h0, busy}, 32'h0);
        chk("abort_idle_led",  {24'h0, led}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
